// File: rtl/uart_pkg.sv
// Constants shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int unsigned FCLK_DEFAULT = 50000000;
  localparam int unsigned FBIT_DEFAULT = 115200;

  // Frame layout: start bit (index 0), N_DATA data bits, stop bit at index CB_STOP.
  localparam int unsigned N_DATA  = 8;
  localparam logic [3:0]  CB_STOP = 4'd9;

  // Clocks per bit interval.
  function automatic int unsigned clks_per_bit(input int unsigned fclk, input int unsigned fbit);
    return fclk / fbit;
  endfunction

endpackage

// File: rtl/urxd_byte_if.sv
// Serial line plus receiver status/data outputs.
interface urxd_byte_if;

  logic       RXD;
  logic       en_rx_byte;
  logic [3:0] cb_bit;
  logic       ce_bit;
  logic [7:0] dat;
  logic       ok_rx;
  logic       err_frame;

  // Line driver / byte consumer side.
  modport master (
    output RXD,
    input  en_rx_byte, cb_bit, ce_bit, dat, ok_rx, err_frame
  );

  // Receiver side.
  modport slave (
    input  RXD,
    output en_rx_byte, cb_bit, ce_bit, dat, ok_rx, err_frame
  );

endinterface

// File: rtl/urx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high input, plus a history
// flop that yields a one-cycle falling-edge indication.
module urx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic rx_m_q, rx_s_q, rx_d_q;

  // Synchroniser chain; all stages reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
    end else begin
      rx_m_q <= d_i;
      rx_s_q <= rx_m_q;
      rx_d_q <= rx_s_q;
    end
  end

  assign q_o    = rx_s_q;
  assign fall_o = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/urxd_byte.sv
// UART byte receiver: 1 start, 8 data (LSB first), 1 stop bit, mid-bit sampling.
// Control state is just en_rx_byte plus the bit index; Nt = Fclk/Fbit must be >= 4.
module urxd_byte
  import uart_pkg::*;
#(
  parameter int unsigned Fclk = FCLK_DEFAULT,
  parameter int unsigned Fbit = FBIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  urxd_byte_if.slave  bus
);

  localparam int unsigned Nt     = clks_per_bit(Fclk, Fbit);
  localparam int unsigned NtHalf = Nt / 2;

  logic              rx_s;
  logic              rx_fall;
  logic              start;
  logic              ce_tact;
  logic              ce_bit;

  logic              en_q, en_d;
  logic [3:0]        cb_bit_q, cb_bit_d;
  logic [31:0]       cb_tact_q, cb_tact_d;
  logic [N_DATA-1:0] sr_q, sr_d;
  logic [7:0]        dat_q, dat_d;
  logic              ok_q, ok_d;
  logic              err_q, err_d;

  urx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.RXD),
    .q_o    (rx_s),
    .fall_o (rx_fall)
  );

  assign start   = rx_fall & ~en_q;
  assign ce_tact = (cb_tact_q == Nt);
  assign ce_bit  = en_q & (cb_tact_q == NtHalf);

  // Next-state for the bit timer, bit index, shift register and strobes.
  always_comb begin
    en_d      = en_q;
    cb_bit_d  = cb_bit_q;
    cb_tact_d = cb_tact_q;
    sr_d      = sr_q;
    dat_d     = dat_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;

    if (start) begin
      en_d      = 1'b1;
      cb_tact_d = 32'd1;
      cb_bit_d  = 4'd0;
    end else if (en_q) begin
      cb_tact_d = ce_tact ? 32'd1 : cb_tact_q + 32'd1;
      if (ce_tact) begin
        cb_bit_d = cb_bit_q + 4'd1;
      end
      // ce_bit and ce_tact never coincide since NtHalf < Nt.
      if (ce_bit) begin
        if (cb_bit_q == 4'd0) begin
          // Line back high mid start bit: treat as a glitch and drop the frame.
          if (rx_s) begin
            en_d      = 1'b0;
            cb_bit_d  = 4'd0;
            cb_tact_d = 32'd0;
          end
        end else if (cb_bit_q <= 4'(N_DATA)) begin
          sr_d = {rx_s, sr_q[N_DATA-1:1]};
        end else begin
          // Stop bit: finish at its sample point so a following start is not missed.
          if (rx_s) begin
            dat_d = sr_q;
            ok_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          en_d      = 1'b0;
          cb_bit_d  = 4'd0;
          cb_tact_d = 32'd0;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q      <= 1'b0;
      cb_bit_q  <= 4'd0;
      cb_tact_q <= 32'd0;
      sr_q      <= '0;
      dat_q     <= 8'h00;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      cb_bit_q  <= cb_bit_d;
      cb_tact_q <= cb_tact_d;
      sr_q      <= sr_d;
      dat_q     <= dat_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
    end
  end

  assign bus.en_rx_byte = en_q;
  assign bus.cb_bit     = cb_bit_q;
  assign bus.ce_bit     = ce_bit;
  assign bus.dat        = dat_q;
  assign bus.ok_rx      = ok_q;
  assign bus.err_frame  = err_q;

endmodule

// File: doc/urxd_byte.md
# urxd_byte

UART byte receiver. It is the downstream partner of the team's 1-start/8-data/1-stop transmitter and consumes the serial line that transmitter drives. The block synchronises the asynchronous line, detects the start bit and samples every bit at mid-interval. It delivers the byte with a one-cycle valid strobe, or raises a frame-error strobe.

## Interface
Parameters:
- Fclk, 50000000: system clock frequency, Hz.
- Fbit, 115200: line bit rate, bit/s.
- Nt, Fclk/Fbit: clocks per bit. Derived; Nt ≥ 4 required.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- RXD  in  1  asynchronous serial input; idle high.
- en_rx_byte  out  1  frame in progress (start bit through stop-bit sample).
- cb_bit  out  4  bit index in frame: 0 = start, 1..8 = data, 9 = stop.
- ce_bit  out  1  mid-bit sample strobe, one clk wide.
- dat  out  8  last correctly received byte; held until the next good frame.
- ok_rx  out  1  one-clk pulse: new byte on dat.
- err_frame  out  1  one-clk pulse: stop bit sampled low; dat not updated.

## Operation
- Synchroniser: two flops, rx_m then rx_s, plus a history flop rx_d. All three reset to 1.
- Start detect: start = rx_d & !rx_s & !en_rx_byte. On start:
  - en_rx_byte <= 1
  - cb_tact <= 1
  - cb_bit <= 0
- Tact counter cb_tact (32 bit):
  - Counts 1..Nt while en_rx_byte is high; ce_tact = (cb_tact==Nt), and it reloads to 1 on ce_tact.
  - cb_bit increments on ce_tact & en_rx_byte.
  - Holds at 0 when idle.
- Sampling: ce_bit = en_rx_byte & (cb_tact == Nt/2) (integer division). All decisions below use rx_s.
- cb_bit==0 at ce_bit:
  - rx_s==1 means a false start: en_rx_byte <= 0, cb_bit <= 0, no strobe.
  - Otherwise continue.
- cb_bit 1..8 at ce_bit: sr <= {rx_s, sr[7:1]}. Data arrives LSB first, so after bit 8, sr[0] is the first data bit.
- cb_bit==9 at ce_bit:
  - rx_s==1: dat <= sr, ok_rx <= 1.
  - rx_s==0: err_frame <= 1.
  - In both cases en_rx_byte <= 0 and cb_bit <= 0.
  - The receiver does not wait for the end of the stop bit; this tolerates up to about ±5% rate mismatch for back-to-back frames.
- Idle after a frame: a new start needs a 1→0 transition on rx_s. After err_frame with the line held low (break), no new frame starts until the line has been high for at least one clk.
- Reset values: en_rx_byte=0, cb_bit=0, ce_bit=0, dat=8'h00, ok_rx=0, err_frame=0, sr=0, cb_tact=0.
- Reset mid-frame aborts the frame silently: no strobe, dat keeps its reset value.

## Timing
- RXD fall to en_rx_byte=1: 3 clk edges (2 synchroniser flops + start register).
- The first ce_bit comes Nt/2 − 1 clk after en_rx_byte rises. Each later ce_bit is exactly Nt clk after the previous one.
- On the clk edge where ce_bit and cb_bit==9 are both high, dat, ok_rx/err_frame and en_rx_byte=0 all update together. The strobe is high for exactly the following cycle.
- ok_rx and err_frame are mutually exclusive.
- Earliest new start detection is the cycle after en_rx_byte falls. Any RXD fall inside the stop bit after its sample point is accepted.
- A glitch shorter than Nt/2 clk produces a false start: en_rx_byte pulses, then drops with no strobe.

## Structure
- Shared package (uart_pkg): Fclk default, Fbit default, N_DATA=8, CB_STOP=9. The transmitter uses the same constants.
- One natural sub-module: urx_sync, the 2-flop synchroniser plus history flop with a falling-edge output. It is reusable for other asynchronous inputs.
- The rest of the block is a flat counter/shift-register datapath with no explicit FSM encoding: the state is en_rx_byte plus cb_bit.

## Test plan
Use Fclk=1000, Fbit=100, so Nt=10. Drive RXD with a behavioural 10-clk-per-bit model, or loop back from the existing transmitter.
- Send 8'hA5 with a good stop bit -> one ok_rx pulse, dat=8'hA5, err_frame never high, ce_bit exactly 10 pulses.
- Send 8'h3C then 8'hC3 back to back (stop bit 10 clk) -> two ok_rx pulses 100 clk apart, dat=8'h3C then 8'hC3.
- Send 8'hFF with the stop bit forced low -> err_frame one pulse, ok_rx 0, dat retains its previous value. Then hold RXD low for 50 clk and release -> no further strobes.
- Drive RXD low for 3 clk only -> en_rx_byte high for about 5 clk, then 0. No ok_rx or err_frame; cb_bit back to 0.
- Assert rst for 1 clk while cb_bit==4 -> next cycle all outputs at reset values. A following 8'h55 frame is received correctly.
- Rate mismatch: sender at 10.5 clk/bit sending 8'h96 -> ok_rx with dat=8'h96. At 9.5 clk/bit -> same result.
